// File: rtl/if_fetch_ctrl_pkg.sv
// Shared types and constants for the Thumb fetch controller.
// Build option IF_FETCH_CTRL_PREFETCH_EN (used in if_fetch_ctrl) selects a 2-entry output FIFO.
package if_fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    FLUSH = 2'd3
  } fetch_state_t;

  localparam logic [15:0] THUMB_NOP = 16'h0000;
  localparam logic [31:0] PC_INC    = 32'd2;

  typedef struct packed {
    logic        vld;
    logic [15:0] inst;
    logic [31:0] pc;
  } if_entry_t;

  localparam if_entry_t ENTRY_EMPTY = '{vld: 1'b0, inst: THUMB_NOP, pc: 32'h0};

  // Shared 32-bit adder, wraps modulo 2^32.
  function automatic logic [31:0] add32(input logic [31:0] a, input logic [31:0] b);
    return a + b;
  endfunction

endpackage

// File: rtl/if_fetch_ctrl_npc_gen.sv
// Next fetch PC: sequential halfword increment or PC-relative branch target.
module if_npc_gen
  import if_fetch_ctrl_pkg::*;
(
  input  logic [31:0] pc,
  input  logic        br_taken,
  input  logic [31:0] br_offset,
  output logic [31:0] npc
);

  logic [31:0] pc_seq, pc_rel;

  assign pc_seq = add32(pc, PC_INC);
  // Branch offsets are halfword aligned; bit 0 is forced low.
  assign pc_rel = add32(pc, br_offset & ~32'd1);
  assign npc    = br_taken ? pc_rel : pc_seq;

endmodule

// File: rtl/if_fetch_ctrl.sv
// Thumb fetch controller: fetch PC, imem request sequencing, decode output buffer.
// Define IF_FETCH_CTRL_PREFETCH_EN for a 2-entry output FIFO; default is a single register.
module if_fetch_ctrl
  import if_fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        nRESET,
  output logic        IMEM_REQ,
  output logic [31:0] IMEM_ADDR,
  input  logic        IMEM_RDY,
  input  logic [15:0] IMEM_RDATA,
  input  logic        BR_TAKEN,
  input  logic [31:0] BR_OFFSET,
  input  logic        ID_STALL,
  output logic        IF_VALID,
  output logic [15:0] IF_INST,
  output logic [31:0] IF_PC_OUT
);

`ifdef IF_FETCH_CTRL_PREFETCH_EN
  localparam logic [1:0] BUF_DEPTH = 2'd2;
`else
  localparam logic [1:0] BUF_DEPTH = 2'd1;
`endif
  localparam logic [31:0] PC_RST = RESET_VECTOR & ~32'd1;

  fetch_state_t state, state_nxt;
  logic [31:0]  fetch_pc, npc;
  if_entry_t    e0, e1, e0_nxt, e1_nxt, new_ent;
  logic         br, pop, room, acc;
  logic [1:0]   cnt, cnt_nxt;

  assign br   = BR_TAKEN && (state != IDLE);
  assign pop  = e0.vld && !ID_STALL;
  assign cnt  = 2'(e0.vld) + 2'(e1.vld);
  assign room = (cnt < BUF_DEPTH) || pop;
  // A handshake into a full, stalled buffer is dropped and PC holds, so the
  // same address is simply refetched once decode drains.
  assign acc  = (state == FETCH) && IMEM_RDY && room && !br;

  assign new_ent = '{vld: 1'b1, inst: IMEM_RDATA, pc: fetch_pc};

  assign IMEM_REQ  = (state == FETCH);
  assign IMEM_ADDR = fetch_pc;

  if_npc_gen u_npc (
    .pc       (fetch_pc),
    .br_taken (br),
    .br_offset(BR_OFFSET),
    .npc      (npc)
  );

  // e0 is the head and drives decode; e1 only fills in prefetch builds.
  always_comb begin
    e0_nxt = e0;
    e1_nxt = e1;
    if (br) begin
      e0_nxt = ENTRY_EMPTY;
      e1_nxt = ENTRY_EMPTY;
    end else begin
      if (pop) begin
        e0_nxt = e1;
        e1_nxt = ENTRY_EMPTY;
      end
      if (acc) begin
        if (!e0_nxt.vld) e0_nxt = new_ent;
        else             e1_nxt = new_ent;
      end
    end
  end

  assign cnt_nxt = 2'(e0_nxt.vld) + 2'(e1_nxt.vld);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = FETCH;
      FETCH:   if (cnt_nxt == BUF_DEPTH && ID_STALL) state_nxt = HOLD;
      HOLD:    if (pop) state_nxt = FETCH;
      FLUSH:   state_nxt = FETCH;
      default: state_nxt = IDLE;
    endcase
    if (br) state_nxt = FLUSH;
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      state    <= IDLE;
      fetch_pc <= PC_RST;
      e0       <= ENTRY_EMPTY;
      e1       <= ENTRY_EMPTY;
    end else begin
      state <= state_nxt;
      if (br || acc) fetch_pc <= npc;
      e0 <= e0_nxt;
      e1 <= e1_nxt;
    end
  end

  assign IF_VALID  = e0.vld;
  assign IF_INST   = e0.inst;
  assign IF_PC_OUT = e0.pc;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Directed self-checking bench for if_fetch_ctrl (RESET_VECTOR = 0x100).
module tb_if_fetch_ctrl;

  logic        CLK = 1'b0, nRESET = 1'b1;
  logic        IMEM_RDY = 1'b0, BR_TAKEN = 1'b0, ID_STALL = 1'b0;
  logic [31:0] BR_OFFSET = 32'h0;
  logic [15:0] IMEM_RDATA;
  logic        IMEM_REQ, IF_VALID;
  logic [31:0] IMEM_ADDR, IF_PC_OUT;
  logic [15:0] IF_INST;
  int total = 0, bad = 0;

`ifdef IF_FETCH_CTRL_PREFETCH_EN
  localparam int PF = 1;
`else
  localparam int PF = 0;
`endif

  if_fetch_ctrl #(.RESET_VECTOR(32'h0000_0100)) dut (
    .CLK(CLK), .nRESET(nRESET),
    .IMEM_REQ(IMEM_REQ), .IMEM_ADDR(IMEM_ADDR), .IMEM_RDY(IMEM_RDY), .IMEM_RDATA(IMEM_RDATA),
    .BR_TAKEN(BR_TAKEN), .BR_OFFSET(BR_OFFSET), .ID_STALL(ID_STALL),
    .IF_VALID(IF_VALID), .IF_INST(IF_INST), .IF_PC_OUT(IF_PC_OUT)
  );

  always #5 CLK = ~CLK;

  // Instruction memory: a distinct nonzero halfword per address.
  function automatic logic [15:0] mem(input logic [31:0] a);
    return a[16:1] + 16'h1000;
  endfunction
  assign IMEM_RDATA = mem(IMEM_ADDR);

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic apply_reset();
    IMEM_RDY = 1'b1; BR_TAKEN = 1'b0; ID_STALL = 1'b0; BR_OFFSET = 32'h0;
    #2 nRESET = 1'b0;
    tick(); tick();
    nRESET = 1'b1;
  endtask

  task automatic test_reset();
    IMEM_RDY = 1'b1;
    #2 nRESET = 1'b0;
    tick(); tick();
    total++; if (IMEM_REQ !== 1'b0) begin bad++; $display("FAIL rst_req got=%b exp=0", IMEM_REQ); end
    total++; if (IMEM_ADDR !== 32'h100) begin bad++; $display("FAIL rst_addr got=%h exp=100", IMEM_ADDR); end
    total++; if (IF_VALID !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", IF_VALID); end
    total++; if (IF_INST !== 16'h0) begin bad++; $display("FAIL rst_inst got=%h exp=0", IF_INST); end
    total++; if (IF_PC_OUT !== 32'h0) begin bad++; $display("FAIL rst_pcout got=%h exp=0", IF_PC_OUT); end
    nRESET = 1'b1;                                                       // cycle 0
    total++; if (IMEM_REQ !== 1'b0) begin bad++; $display("FAIL idle_req got=%b exp=0", IMEM_REQ); end
    tick();                                                              // cycle 1
    total++; if (IMEM_REQ !== 1'b1 || IMEM_ADDR !== 32'h100) begin bad++; $display("FAIL c1_fetch got=%b/%h exp=1/100", IMEM_REQ, IMEM_ADDR); end
    total++; if (IF_VALID !== 1'b0) begin bad++; $display("FAIL c1_valid got=%b exp=0", IF_VALID); end
    tick();                                                              // cycle 2
    total++; if (IMEM_ADDR !== 32'h102) begin bad++; $display("FAIL c2_addr got=%h exp=102", IMEM_ADDR); end
    total++; if (IF_VALID !== 1'b1 || IF_PC_OUT !== 32'h100 || IF_INST !== mem(32'h100)) begin bad++; $display("FAIL c2_out got=%b/%h/%h exp=1/100/%h", IF_VALID, IF_PC_OUT, IF_INST, mem(32'h100)); end
    tick();                                                              // cycle 3
    total++; if (IMEM_ADDR !== 32'h104 || IF_PC_OUT !== 32'h102) begin bad++; $display("FAIL c3_stream got=%h/%h exp=104/102", IMEM_ADDR, IF_PC_OUT); end
  endtask

  task automatic test_rdy_stall();
    IMEM_RDY = 1'b0;                                                     // cycles 3,4,5 not ready
    tick();
    total++; if (IMEM_ADDR !== 32'h104 || IF_VALID !== 1'b0) begin bad++; $display("FAIL rdy0_a got=%h/%b exp=104/0", IMEM_ADDR, IF_VALID); end
    tick();
    total++; if (IMEM_ADDR !== 32'h104 || IMEM_REQ !== 1'b1) begin bad++; $display("FAIL rdy0_b got=%h/%b exp=104/1", IMEM_ADDR, IMEM_REQ); end
    tick();
    IMEM_RDY = 1'b1;
    total++; if (IMEM_ADDR !== 32'h104 || IF_VALID !== 1'b0) begin bad++; $display("FAIL rdy0_c got=%h/%b exp=104/0", IMEM_ADDR, IF_VALID); end
    tick();
    total++; if (IF_VALID !== 1'b1 || IF_PC_OUT !== 32'h104 || IF_INST !== mem(32'h104) || IMEM_ADDR !== 32'h106) begin bad++; $display("FAIL rdy_resume got=%b/%h/%h/%h exp=1/104/%h/106", IF_VALID, IF_PC_OUT, IF_INST, IMEM_ADDR, mem(32'h104)); end
  endtask

  task automatic test_id_stall();
    ID_STALL = 1'b1;                                                     // cycles 7..10 stalled
    for (int k = 0; k < 3; k++) begin
      tick();
      total++; if (IMEM_REQ !== 1'b0 || IF_VALID !== 1'b1 || IF_PC_OUT !== 32'h104 || IF_INST !== mem(32'h104)) begin bad++; $display("FAIL stall_hold%0d got=%b/%b/%h/%h exp=0/1/104/%h", k, IMEM_REQ, IF_VALID, IF_PC_OUT, IF_INST, mem(32'h104)); end
    end
    tick();
    ID_STALL = 1'b0;
    total++; if (IMEM_REQ !== 1'b0 || IF_PC_OUT !== 32'h104 || IMEM_ADDR !== 32'h106 + 32'(2*PF)) begin bad++; $display("FAIL stall_rel got=%b/%h/%h exp=0/104/%h", IMEM_REQ, IF_PC_OUT, IMEM_ADDR, 32'h106 + 32'(2*PF)); end
    tick();
    total++; if (IMEM_REQ !== 1'b1 || IMEM_ADDR !== 32'h106 + 32'(2*PF)) begin bad++; $display("FAIL stall_refetch got=%b/%h exp=1/%h", IMEM_REQ, IMEM_ADDR, 32'h106 + 32'(2*PF)); end
    total++; if (IF_VALID !== 1'(PF) || IF_INST !== (PF != 0 ? mem(32'h106) : 16'h0000)) begin bad++; $display("FAIL stall_buf got=%b/%h exp=%0d", IF_VALID, IF_INST, PF); end
    tick();
    total++; if (IF_VALID !== 1'b1 || IF_PC_OUT !== 32'h106 + 32'(2*PF)) begin bad++; $display("FAIL stall_next got=%b/%h exp=1/%h", IF_VALID, IF_PC_OUT, 32'h106 + 32'(2*PF)); end
  endtask

  task automatic test_branch();
    apply_reset();
    tick();                                                              // c1 FETCH @100
    BR_TAKEN = 1'b1; BR_OFFSET = 32'h100;
    tick();                                                              // c2 FLUSH
    BR_TAKEN = 1'b0;
    total++; if (IMEM_REQ !== 1'b0 || IF_VALID !== 1'b0) begin bad++; $display("FAIL br1_flush got=%b/%b exp=0/0", IMEM_REQ, IF_VALID); end
    tick();                                                              // c3 FETCH @200
    total++; if (IMEM_REQ !== 1'b1 || IMEM_ADDR !== 32'h200) begin bad++; $display("FAIL br1_tgt got=%b/%h exp=1/200", IMEM_REQ, IMEM_ADDR); end
    BR_TAKEN = 1'b1; BR_OFFSET = 32'hFFFF_FFF0;
    tick();                                                              // c4 FLUSH, data from 200 dropped
    BR_TAKEN = 1'b0;
    total++; if (IF_VALID !== 1'b0 || IF_INST !== 16'h0 || IMEM_REQ !== 1'b0) begin bad++; $display("FAIL br2_flush got=%b/%h/%b exp=0/0/0", IF_VALID, IF_INST, IMEM_REQ); end
    tick();
    total++; if (IMEM_REQ !== 1'b1 || IMEM_ADDR !== 32'h1F0 || IF_VALID !== 1'b0) begin bad++; $display("FAIL br2_tgt got=%b/%h/%b exp=1/1f0/0", IMEM_REQ, IMEM_ADDR, IF_VALID); end
    tick();
    total++; if (IF_VALID !== 1'b1 || IF_PC_OUT !== 32'h1F0 || IF_INST !== mem(32'h1F0)) begin bad++; $display("FAIL br2_first got=%b/%h/%h exp=1/1f0/%h", IF_VALID, IF_PC_OUT, IF_INST, mem(32'h1F0)); end
  endtask

  task automatic test_br_full_stall();
    apply_reset();
    tick(); tick();                                                      // c2 head=100
    ID_STALL = 1'b1;
    tick();                                                              // c3 HOLD, buffer full
    total++; if (IMEM_REQ !== 1'b0 || IF_VALID !== 1'b1 || IF_PC_OUT !== 32'h100) begin bad++; $display("FAIL bfs_hold got=%b/%b/%h exp=0/1/100", IMEM_REQ, IF_VALID, IF_PC_OUT); end
    BR_TAKEN = 1'b1; BR_OFFSET = 32'h40;
    tick();
    BR_TAKEN = 1'b0; ID_STALL = 1'b0;
    total++; if (IF_VALID !== 1'b0 || IF_INST !== 16'h0 || IMEM_REQ !== 1'b0) begin bad++; $display("FAIL bfs_flush got=%b/%h/%b exp=0/0/0", IF_VALID, IF_INST, IMEM_REQ); end
    tick();
    total++; if (IMEM_REQ !== 1'b1 || IMEM_ADDR !== 32'h142 + 32'(2*PF)) begin bad++; $display("FAIL bfs_tgt got=%b/%h exp=1/%h", IMEM_REQ, IMEM_ADDR, 32'h142 + 32'(2*PF)); end
    tick();
    total++; if (IF_VALID !== 1'b1 || IF_PC_OUT !== 32'h142 + 32'(2*PF)) begin bad++; $display("FAIL bfs_first got=%b/%h exp=1/%h", IF_VALID, IF_PC_OUT, 32'h142 + 32'(2*PF)); end
  endtask

  task automatic test_wrap_reset();
    apply_reset();
    tick();
    BR_TAKEN = 1'b1; BR_OFFSET = 32'hFFFF_FEFE;                          // 0x100 -> 0xFFFFFFFE
    tick();
    BR_TAKEN = 1'b0;
    tick();
    total++; if (IMEM_ADDR !== 32'hFFFF_FFFE) begin bad++; $display("FAIL wrap_top got=%h exp=fffffffe", IMEM_ADDR); end
    tick();
    total++; if (IMEM_ADDR !== 32'h0 || IF_PC_OUT !== 32'hFFFF_FFFE || IF_VALID !== 1'b1) begin bad++; $display("FAIL wrap_zero got=%h/%h/%b exp=0/fffffffe/1", IMEM_ADDR, IF_PC_OUT, IF_VALID); end
    #3 nRESET = 1'b0;
    #1;
    total++; if (IMEM_REQ !== 1'b0 || IMEM_ADDR !== 32'h100) begin bad++; $display("FAIL arst_req got=%b/%h exp=0/100", IMEM_REQ, IMEM_ADDR); end
    total++; if (IF_VALID !== 1'b0 || IF_INST !== 16'h0 || IF_PC_OUT !== 32'h0) begin bad++; $display("FAIL arst_out got=%b/%h/%h exp=0/0/0", IF_VALID, IF_INST, IF_PC_OUT); end
    tick();
    nRESET = 1'b1;
  endtask

  initial begin
    test_reset();
    test_rdy_stall();
    test_id_stall();
    test_branch();
    test_br_full_stall();
    test_wrap_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout reached without finishing");
    $fatal(1);
  end

endmodule
